// File: rtl/controller_scanner_pkg.sv
// rtl/controller_scanner_pkg.sv - shared types and constants for the controller scanner
package controller_scanner_pkg;

    localparam int NUM_BUTTONS_DEFAULT = 8;

    // Bit positions within buttons_n; A is shifted out first.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LOW    = 3'd2,
        HIGH   = 3'd3,
        COMMIT = 3'd4
    } scan_state_t;

endpackage

// File: rtl/sync_2ff_m.sv
// rtl/sync_2ff_m.sv - generic 1-bit two-flop synchroniser
module sync_2ff_m #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/controller_scanner.sv
// rtl/controller_scanner.sv - polls two serial controllers and commits both button bytes atomically
module controller_scanner
    import controller_scanner_pkg::*;
#(
    parameter int HALF_PERIOD = 6,
    parameter int NUM_BUTTONS = NUM_BUTTONS_DEFAULT
) (
    input  logic                   clk_1,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear_press,
    input  logic                   controller_1_data_in_B,
    input  logic                   controller_2_data_in_B,
    output logic                   controller_clk,
    output logic                   controller_latch,
    output logic [NUM_BUTTONS-1:0] buttons_1,
    output logic [NUM_BUTTONS-1:0] buttons_2,
    output logic [NUM_BUTTONS-1:0] new_press_1,
    output logic [NUM_BUTTONS-1:0] new_press_2,
    output logic                   busy,
    output logic                   done
);

    if (HALF_PERIOD < 3) begin : g_bad_half_period
        $error("controller_scanner: HALF_PERIOD must be >= 3");
    end

    localparam int CNT_W = $clog2(2 * HALF_PERIOD);
    localparam int BIT_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

    scan_state_t            r_state;
    scan_state_t            w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit;
    logic                   w_phase_last;
    logic                   r_clk;
    logic                   r_latch;
    logic                   r_done;
    logic [NUM_BUTTONS-1:0] r_shadow_1;
    logic [NUM_BUTTONS-1:0] r_shadow_2;
    logic [NUM_BUTTONS-1:0] r_buttons_1;
    logic [NUM_BUTTONS-1:0] r_buttons_2;
    logic [NUM_BUTTONS-1:0] r_new_press_1;
    logic [NUM_BUTTONS-1:0] r_new_press_2;
    logic                   w_data_1_B;
    logic                   w_data_2_B;

    // Lines idle high (released), so the synchronisers reset to 1.
    sync_2ff_m #(.RESET_VALUE(1'b1)) u_sync_1 (
        .i_clk (clk_1),
        .i_rst (rst),
        .i_d   (controller_1_data_in_B),
        .o_q   (w_data_1_B)
    );

    sync_2ff_m #(.RESET_VALUE(1'b1)) u_sync_2 (
        .i_clk (clk_1),
        .i_rst (rst),
        .i_d   (controller_2_data_in_B),
        .o_q   (w_data_2_B)
    );

    always_comb begin
        w_phase_last = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = LATCH;
            end
            LATCH: begin
                w_phase_last = (r_cnt == CNT_W'(2 * HALF_PERIOD - 1));
                if (w_phase_last) w_next_state = LOW;
            end
            LOW: begin
                w_phase_last = (r_cnt == CNT_W'(HALF_PERIOD - 1));
                if (w_phase_last) begin
                    w_next_state = (r_bit == BIT_W'(NUM_BUTTONS - 1)) ? COMMIT : HIGH;
                end
            end
            HIGH: begin
                w_phase_last = (r_cnt == CNT_W'(HALF_PERIOD - 1));
                if (w_phase_last) w_next_state = LOW;
            end
            COMMIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_clk         <= 1'b0;
            r_latch       <= 1'b0;
            r_done        <= 1'b0;
            r_shadow_1    <= '0;
            r_shadow_2    <= '0;
            r_buttons_1   <= '0;
            r_buttons_2   <= '0;
            r_new_press_1 <= '0;
            r_new_press_2 <= '0;
        end else begin
            r_state <= w_next_state;
            // Pin outputs decode the next state so they come straight off flops.
            r_latch <= (w_next_state == LATCH);
            r_clk   <= (w_next_state == HIGH);
            r_done  <= (r_state == COMMIT);

            if (r_state == IDLE || w_next_state != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == IDLE) begin
                r_bit <= '0;
            end else if (r_state == HIGH && w_phase_last) begin
                r_bit <= r_bit + 1'b1;
            end

            if (r_state == LOW && w_phase_last) begin
                r_shadow_1 <= {r_shadow_1[NUM_BUTTONS-2:0], ~w_data_1_B};
                r_shadow_2 <= {r_shadow_2[NUM_BUTTONS-2:0], ~w_data_2_B};
            end

            // A coincident clear drops only the old flags; edges found now survive.
            if (r_state == COMMIT) begin
                r_buttons_1   <= r_shadow_1;
                r_buttons_2   <= r_shadow_2;
                r_new_press_1 <= (clear_press ? '0 : r_new_press_1) | (r_shadow_1 & ~r_buttons_1);
                r_new_press_2 <= (clear_press ? '0 : r_new_press_2) | (r_shadow_2 & ~r_buttons_2);
            end else if (clear_press) begin
                r_new_press_1 <= '0;
                r_new_press_2 <= '0;
            end
        end
    end

    assign controller_clk   = r_clk;
    assign controller_latch = r_latch;
    assign buttons_1        = r_buttons_1;
    assign buttons_2        = r_buttons_2;
    assign new_press_1      = r_new_press_1;
    assign new_press_2      = r_new_press_2;
    assign busy             = (r_state != IDLE);
    assign done             = r_done;

endmodule

// File: tb/tb_controller_scanner.sv
// tb/tb_controller_scanner.sv - self-checking bench for controller_scanner
module tb_controller_scanner;

    localparam int H  = 6;
    localparam int NB = 8;

    logic          clk_1 = 1'b0;
    logic          rst;
    logic          start;
    logic          clear_press;
    logic          d1_B;
    logic          d2_B;
    logic          controller_clk;
    logic          controller_latch;
    logic [NB-1:0] buttons_1;
    logic [NB-1:0] buttons_2;
    logic [NB-1:0] new_press_1;
    logic [NB-1:0] new_press_2;
    logic          busy;
    logic          done;

    controller_scanner #(.HALF_PERIOD(H), .NUM_BUTTONS(NB)) dut (
        .clk_1                  (clk_1),
        .rst                    (rst),
        .start                  (start),
        .clear_press            (clear_press),
        .controller_1_data_in_B (d1_B),
        .controller_2_data_in_B (d2_B),
        .controller_clk         (controller_clk),
        .controller_latch       (controller_latch),
        .buttons_1              (buttons_1),
        .buttons_2              (buttons_2),
        .new_press_1            (new_press_1),
        .new_press_2            (new_press_2),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clk_1 = ~clk_1;

    // Controller model: parallel load while latched, shift out MSB first on each clock rise.
    logic [NB-1:0] pressed_1 = '0;
    logic [NB-1:0] pressed_2 = '0;
    logic [NB-1:0] sr_1 = '0;
    logic [NB-1:0] sr_2 = '0;
    logic          prev_cclk = 1'b0;

    always @(negedge clk_1) begin
        if (controller_latch) begin
            sr_1 = pressed_1;
            sr_2 = pressed_2;
        end else if (controller_clk && !prev_cclk) begin
            sr_1 = sr_1 << 1;
            sr_2 = sr_2 << 1;
        end
        prev_cclk = controller_clk;
    end

    assign d1_B = ~sr_1[NB-1];
    assign d2_B = ~sr_2[NB-1];

    int   n_rise = 0;
    int   n_latch = 0;
    int   n_overlap = 0;
    int   n_done = 0;
    logic mon_prev_clk = 1'b0;

    always @(negedge clk_1) begin
        if (controller_clk && !mon_prev_clk) n_rise = n_rise + 1;
        if (controller_latch) n_latch = n_latch + 1;
        if (controller_clk && controller_latch) n_overlap = n_overlap + 1;
        if (done) n_done = n_done + 1;
        mon_prev_clk = controller_clk;
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [NB-1:0] m_b1 = '0;
    logic [NB-1:0] m_b2 = '0;
    logic [NB-1:0] m_np1 = '0;
    logic [NB-1:0] m_np2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk"}, controller_clk, 0);
        check({tag, "_latch"}, controller_latch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_buttons"}, {buttons_2, buttons_1}, 0);
        check({tag, "_new_press"}, {new_press_2, new_press_1}, 0);
    endtask

    task automatic run_scan(input logic [NB-1:0] p1, input logic [NB-1:0] p2,
                            input bit mid_start, input bit clr_commit);
        int            cyc;
        int            r0;
        int            l0;
        int            o0;
        int            d0;
        logic [NB-1:0] e_np1;
        logic [NB-1:0] e_np2;
        pressed_1 = p1;
        pressed_2 = p2;
        e_np1 = (clr_commit ? '0 : m_np1) | (p1 & ~m_b1);
        e_np2 = (clr_commit ? '0 : m_np2) | (p2 & ~m_b2);
        r0 = n_rise;
        l0 = n_latch;
        o0 = n_overlap;
        d0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("latch_after_start", controller_latch, 1);
        check("busy_after_start", busy, 1);
        cyc = 1;
        while (!done && cyc < 300) begin
            start       = mid_start && (cyc == 40);
            clear_press = clr_commit && (cyc == 2 * H + NB * H + (NB - 1) * H + 1);
            tick();
            cyc++;
        end
        start       = 1'b0;
        clear_press = 1'b0;
        check("done_cycle", cyc, 2 * H + NB * H + (NB - 1) * H + 2);
        check("buttons_1", buttons_1, p1);
        check("buttons_2", buttons_2, p2);
        check("new_press_1", new_press_1, e_np1);
        check("new_press_2", new_press_2, e_np2);
        check("busy_at_done", busy, 0);
        check("clk_rises", n_rise - r0, NB - 1);
        check("latch_cycles", n_latch - l0, 2 * H);
        check("clk_latch_overlap", n_overlap - o0, 0);
        tick();
        check("done_pulse_count", n_done - d0, 1);
        check("done_low_after", done, 0);
        m_b1  = p1;
        m_b2  = p2;
        m_np1 = e_np1;
        m_np2 = e_np2;
    endtask

    initial begin
        int            r0;
        int            l0;
        int            w;
        logic [NB-1:0] p1;
        logic [NB-1:0] p2;
        bit            cl;

        rst         = 1'b1;
        start       = 1'b0;
        clear_press = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        r0 = n_rise;
        l0 = n_latch;
        repeat (500) tick();
        check("idle_clk_rises", n_rise - r0, 0);
        check("idle_latch_cycles", n_latch - l0, 0);
        check_reset_outputs("idle");

        run_scan(8'b1000_1000, 8'b0010_0110, 1'b0, 1'b0);
        run_scan(8'b1100_1000, 8'b0010_0110, 1'b0, 1'b0);
        check("sticky_np1", new_press_1, 8'hC8);

        clear_press = 1'b1;
        tick();
        clear_press = 1'b0;
        m_np1 = '0;
        m_np2 = '0;
        check("cleared_np", {new_press_2, new_press_1}, 0);

        run_scan(8'b1100_1001, 8'b0010_0110, 1'b0, 1'b1);
        check("clear_with_commit_np1", new_press_1, 8'h01);

        run_scan(8'h3C, 8'h81, 1'b1, 1'b0);
        l0 = n_latch;
        repeat (20) tick();
        check("mid_start_not_queued", n_latch - l0, 0);
        check("mid_start_idle", busy, 0);

        for (int k = 0; k < 6; k++) begin
            p1 = NB'($urandom);
            p2 = NB'($urandom);
            cl = 1'($urandom_range(0, 1));
            run_scan(p1, p2, 1'b0, cl);
        end

        run_scan(8'h5A, 8'hA5, 1'b0, 1'b0);
        pressed_1 = 8'hFF;
        pressed_2 = 8'h0F;
        r0 = n_rise;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while ((n_rise - r0) < 5 && w < 300) begin
            tick();
            w++;
        end
        check("reached_high_bit4", n_rise - r0, 5);
        check("high_bit4_clk", controller_clk, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_scan_reset");
        rst = 1'b0;
        m_b1  = '0;
        m_b2  = '0;
        m_np1 = '0;
        m_np2 = '0;
        run_scan(NB'($urandom), NB'($urandom), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controller_scanner.md
# controller_scanner

Polls both serial game controllers and presents their decoded button state to the CPU-side register file. It sits between the controller port pins (`controller_clk`, `controller_latch`, active-low serial data) and the memory-mapped controller registers in `top_m`. It generates the latch/clock waveform, synchronises and de-serialises both data lines, and commits both button bytes atomically. It also keeps sticky "newly pressed" flags for edge-triggered game input.

## Interface
Parameters:
- `HALF_PERIOD`, 6: `clk_1` cycles per controller-clock half period. Must be ≥ 3 (elaboration error otherwise).
- `NUM_BUTTONS`, 8: serial bits read per controller.

Ports:
- `clk_1`  in  1  sole clock (CPU clock domain)
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a scan (driven from vblank start)
- `clear_press`  in  1  one-cycle pulse; clears both `new_press_*` registers
- `controller_1_data_in_B`  in  1  serial data, controller 1, active low, asynchronous
- `controller_2_data_in_B`  in  1  serial data, controller 2, active low, asynchronous
- `controller_clk`  out  1  shift clock to both controllers
- `controller_latch`  out  1  parallel-load strobe to both controllers
- `buttons_1`  out  8  controller 1 state, 1 = pressed
- `buttons_2`  out  8  controller 2 state, 1 = pressed
- `new_press_1`  out  8  sticky bits for controller 1, set on 0→1 transitions of `buttons_1`
- `new_press_2`  out  8  sticky bits for controller 2, set on 0→1 transitions of `buttons_2`
- `busy`  out  1  high while a scan is in progress
- `done`  out  1  one-cycle pulse in the cycle after commit

## Operation
- States: `IDLE`, `LATCH`, `LOW`, `HIGH`, `COMMIT`.
- `IDLE`
  - `start` → `LATCH`.
  - `start` is ignored in every other state; it is not queued.
- `LATCH`
  - `controller_latch`=1 for 2·HALF_PERIOD cycles, then → `LOW`.
- `LOW`
  - `controller_clk`=0 for HALF_PERIOD cycles.
  - In the final cycle, the synchronised, inverted data bits are shifted into per-controller shadow registers, MSB first: the first bit lands in `[7]`.
  - If bit index = NUM_BUTTONS-1 → `COMMIT`, else → `HIGH`.
- `HIGH`
  - `controller_clk`=1 for HALF_PERIOD cycles, bit index +1, then → `LOW`.
  - Exactly NUM_BUTTONS-1 rising edges are produced per scan.
- `COMMIT`, one cycle:
  - `buttons_n` ← shadow.
  - `new_press_n` ← `new_press_n | (shadow & ~buttons_n)`.
  - → `IDLE`.
- Data inputs pass through a 2-flop synchroniser before inversion.
- `clear_press` in the `COMMIT` cycle: the old flags are cleared and the newly detected bits from this commit are still set. Commit wins for new bits.
- `buttons_n` never shows partial scans. Shadow registers are internal only.
- `busy` = (state ≠ `IDLE`).

## Timing
- Reset values: `controller_clk`=0, `controller_latch`=0, `buttons_*`=0, `new_press_*`=0, `busy`=0, `done`=0, state `IDLE`, shadows 0.
- `rst` mid-scan: in the next cycle all of the above hold and the partial scan is discarded.
- `start` sampled at edge t → `controller_latch`=1 and `busy`=1 from t+1.
- Scan length: 2H + NUM_BUTTONS·H + (NUM_BUTTONS−1)·H cycles, then 1 `COMMIT` cycle.
  - With H=6: latch high 12 cycles, 7 clock pulses, commit in cycle 103 after `start`.
  - `done` is high in cycle 104.
  - `start` is accepted again from cycle 104.
- Each bit is sampled H−1 cycles after the preceding latch fall or clock rise. The synchroniser latency of 2 is covered by H ≥ 3.
- `controller_clk` and `controller_latch` are registered outputs; they are glitch-free and never high at the same time.

## Structure
- `controller_scanner_pkg` holds:
  - the state enum
  - the `NUM_BUTTONS` default
  - button bit-index constants (A=7, B=6, SELECT=5, START=4, UP=3, DOWN=2, LEFT=1, RIGHT=0)
- Sub-module `sync_2ff_m`: generic 1-bit 2-flop synchroniser, one instance per data line.
- The FSM, the shared half-period counter and the bit counter live in `controller_scanner`.

## Test plan
- Reset then idle: all outputs 0, and no `controller_clk` or `controller_latch` activity for 500 cycles.
- Models pressed 8'b10001000 / 8'b00100110, one `start`: `buttons_1`=8'h88, `buttons_2`=8'h26 at cycle 103; exactly 7 `controller_clk` rises; `done` pulses once.
- Second scan with controller 1 pressing 8'b11001000: `new_press_1`=8'hC8 (sticky 8'h88 | new 8'h40); `clear_press` afterwards → 8'h00.
- `clear_press` coincident with a commit that newly adds bit 0: `new_press` = exactly 8'h01.
- `start` pulsed again mid-scan: ignored, and the scan length is unchanged at 103 cycles.
- `rst` asserted during `HIGH` of bit 4: next cycle outputs are at reset values, and the previously committed `buttons_*` are cleared to 0.
